fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR controller that shares one external 16-bit signed saturating multiplier across all filter taps. It sits between the sample source and the filter output. It owns the sample delay line, the coefficient bank and a saturating accumulator. Per accepted sample it sequences TAPS multiply-accumulate cycles through the shared multiplier, then presents one filtered result under a valid/ready handshake.

---
 rtl/fir_mac_sequencer_if.sv | 30 +++
 rtl/fir_mac_sequencer.sv | 71 +++++++
 tb/tb_fir_mac_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample, coefficient, shared-multiplier and result
// handshake signals of the time-multiplexed FIR controller.
interface fir_mac_sequencer_if #(
    parameter int TAPS = 4,
    parameter int DW   = 16
);
    localparam int AW = $clog2(TAPS);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_data;
    logic          coef_ready;
    logic [DW-1:0] mult_a;
    logic [DW-1:0] mult_b;
    logic [DW-1:0] mult_result;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, mult_result, out_ready,
        output in_ready, coef_ready, mult_a, mult_b, out_valid, out_data, busy
    );
    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data, mult_result, out_ready,
        input  in_ready, coef_ready, mult_a, mult_b, out_valid, out_data, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: FIR controller sharing one external saturating multiplier
// across all taps, one MAC per cycle, result offered under valid/ready.
module fir_mac_sequencer #(
    parameter int TAPS = 4,
    parameter int DW   = 16
) (
    input logic                 system1000,
    input logic                 system1000_rst,
    fir_mac_sequencer_if.slave  bus
);
    localparam int AW = $clog2(TAPS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] x_q [TAPS];
    logic [DW-1:0] coef_q [TAPS];
    logic [DW-1:0] acc_q, acc_d;
    logic [AW-1:0] idx_q;
    logic [DW:0]   sum;
    logic          idle, mac, outst, last;

    assign idle  = state_q == IDLE;
    assign mac   = state_q == MAC;
    assign outst = state_q == OUT;
    assign last  = idx_q == AW'(TAPS - 1);

    // Overflow shows as disagreement of the two top bits of the widened sum.
    assign sum   = {acc_q[DW-1], acc_q} + {bus.mult_result[DW-1], bus.mult_result};
    assign acc_d = (sum[DW] ^ sum[DW-1]) ? {sum[DW], {(DW-1){~sum[DW]}}} : sum[DW-1:0];

    always_comb begin
        state_d = (idle && bus.in_valid) ? MAC :
                  (mac && last) ? OUT :
                  (outst && bus.out_ready) ? IDLE : state_q;
    end

    assign bus.in_ready   = idle;
    assign bus.coef_ready = idle;
    assign bus.busy       = mac || outst;
    assign bus.out_valid  = outst;
    assign bus.out_data   = outst ? acc_q : '0;
    assign bus.mult_a     = mac ? x_q[idx_q] : '0;
    assign bus.mult_b     = mac ? coef_q[idx_q] : '0;

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (idle && bus.in_valid) begin
                x_q[0] <= bus.in_data;
                for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
                acc_q <= '0;
                idx_q <= '0;
            end
            if (mac) begin
                acc_q <= acc_d;
                idx_q <= idx_q + 1'b1;
            end
            if (idle && bus.coef_we) coef_q[bus.coef_addr] <= bus.coef_data;
        end
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vector table plus hand-written corner sequences,
// with a behavioural saturating multiplier standing in for the shared unit.
module tb_fir_mac_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic signed [31:0] prod;

    fir_mac_sequencer_if #(.TAPS(4), .DW(16)) bus ();

    fir_mac_sequencer #(.TAPS(4), .DW(16)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        prod = $signed(bus.mult_a) * $signed(bus.mult_b);
        bus.mult_result = (prod > 32767) ? 16'h7fff : (prod < -32768) ? 16'h8000 : prod[15:0];
    end

    typedef struct {
        bit               wr;
        logic [3:0][15:0] c;
        logic [15:0]      smp;
        logic [15:0]      exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coefs(input logic [3:0][15:0] c);
        for (int t = 0; t < 4; t++) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = 2'(t);
            bus.coef_data = c[t];
            tick();
        end
        bus.coef_we = 1'b0;
    endtask

    task automatic accept(input logic [15:0] s);
        bus.in_valid = 1'b1;
        bus.in_data  = s;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [15:0] exp, input bit hs, output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({nm, "_data"}, 32'(bus.out_data), 32'(exp));
        if (hs) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            chk({nm, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
            chk({nm, "_idle"}, {31'd0, bus.in_ready}, 32'd1);
        end
    endtask

    vec_t vecs [7];
    int   n;

    initial begin
        vecs[0] = '{1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 16'd10, 16'd10};
        vecs[1] = '{1'b0, 64'd0, 16'd20, 16'd40};
        vecs[2] = '{1'b0, 64'd0, 16'd30, 16'd100};
        vecs[3] = '{1'b1, {16'd0, 16'd0, 16'd1, 16'h4000}, 16'd4, 16'h7fff};
        vecs[4] = '{1'b0, 64'd0, 16'd0, 16'd4};
        vecs[5] = '{1'b1, {16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff}, 16'h8000, 16'h7ffe};
        vecs[6] = '{1'b0, 64'd0, 16'h8000, 16'hffff};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.coef_we = 1'b0;
        bus.coef_addr = '0; bus.coef_data = '0; bus.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_coef_ready", {31'd0, bus.coef_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_mult", {bus.mult_a, bus.mult_b}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) write_coefs(vecs[i].c);
            accept(vecs[i].smp);
            chk($sformatf("v%0d_mult_a", i), 32'(bus.mult_a), 32'(vecs[i].smp));
            chk($sformatf("v%0d_coef_ready", i), {31'd0, bus.coef_ready}, 32'd0);
            wait_out($sformatf("v%0d", i), vecs[i].exp, 1'b1, n);
            chk($sformatf("v%0d_latency", i), 32'(n), 32'd4);
        end
        accept(16'h8000); wait_out("neg3", 16'h8000, 1'b1, n);
        accept(16'h8000); wait_out("neg4", 16'h8000, 1'b1, n);

        rst = 1'b1; tick(); rst = 1'b0;
        write_coefs({16'd4, 16'd3, 16'd2, 16'd1});
        accept(16'd3);
        wait_out("bp_first", 16'd3, 1'b0, n);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_hold", {15'd0, bus.out_valid, bus.out_data}, 32'h10003);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accept7", {31'd0, bus.busy}, 32'd1);
        wait_out("bp_second", 16'd13, 1'b1, n);

        accept(16'd1);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = 16'd100;
        tick();
        bus.coef_we = 1'b0;
        wait_out("cw_blocked", 16'd24, 1'b1, n);
        bus.coef_we = 1'b1; bus.coef_addr = 2'd0; bus.coef_data = 16'd100;
        accept(16'd2);
        bus.coef_we = 1'b0;
        wait_out("cw_concurrent", 16'd235, 1'b1, n);

        accept(16'd9);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rm_state", {29'd0, bus.out_valid, bus.busy, bus.in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rm_no_pulse", {31'd0, bus.out_valid}, 32'd0);
        end
        accept(16'd5);
        wait_out("rm_cleared_coef", 16'd0, 1'b1, n);
        write_coefs({16'd0, 16'd0, 16'd0, 16'd1});
        accept(16'd6);
        wait_out("rm_rewritten", 16'd6, 1'b1, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
